hazard_scoreboard_unit: RTL and testbench

//  Next-gen hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W). Generalised to

---
 rtl/hazard_scoreboard_unit.sv | 162 ++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Hazard detection and forwarding control for the 5-stage pipeline. It drives stage
// stall/flush, selects per-operand forwarding, tracks one in-flight multi-cycle MDU op
// (latency countdown plus pending destination), and counts decode-stall cycles.
module hazard_scoreboard_unit #(
   parameter int REG_AW = 7,
   parameter int NSRC   = 2,
   parameter int LAT_W  = 6,
   parameter int PERF_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [NSRC*REG_AW-1:0] id_src,
   input  logic [NSRC-1:0]        id_src_used,
   input  logic                   id_is_branch,
   input  logic                   id_mdu,
   input  logic [LAT_W-1:0]       id_mdu_lat,
   input  logic [REG_AW-1:0]      id_mdu_dst,
   input  logic                   ex_regwrite,
   input  logic [REG_AW-1:0]      ex_wreg,
   input  logic                   ex_load,
   input  logic                   mem_regwrite,
   input  logic [REG_AW-1:0]      mem_wreg,
   input  logic                   mem_load,
   input  logic                   mem_ready,
   input  logic                   branch_taken,
   input  logic                   exc_flush,
   output logic                   stall_f,
   output logic                   stall_d,
   output logic                   stall_e,
   output logic                   stall_m,
   output logic                   stall_w,
   output logic                   flush_d,
   output logic                   flush_e,
   output logic                   flush_m,
   output logic                   flush_w,
   output logic [NSRC*2-1:0]      fwd_sel,
   output logic                   mdu_busy,
   output logic [PERF_W-1:0]      stall_cnt
);

   typedef enum logic {IDLE, BUSY} mduStateT;

   mduStateT          mduState;
   logic [LAT_W-1:0]  mduCnt;
   logic [REG_AW-1:0] pendDst;

   logic [NSRC*2-1:0] fwdSel;
   logic [NSRC-1:0]   opHaz;
   logic              haz;
   logic              mduIssue;

   // Per-operand forwarding choice and data-hazard detection; $zero and unread operands never match
   for (genvar k = 0; k < NSRC; k++) begin : gOp
      logic [REG_AW-1:0] src;
      logic              live;
      logic              eMatch;
      logic              mMatch;

      assign src    = id_src[k*REG_AW +: REG_AW];
      assign live   = id_src_used[k] && (src != '0);
      assign eMatch = live && ex_regwrite && (ex_wreg == src);
      assign mMatch = live && mem_regwrite && (mem_wreg == src);

      // E result wins over M; a load still in E cannot forward and stalls instead
      assign fwdSel[k*2 +: 2] = (eMatch && !ex_load) ? 2'b01 :
                                mMatch ? (mem_load ? 2'b11 : 2'b10) : 2'b00;

      // Branches compare in ID, so load data arriving at the end of M is already too late
      assign opHaz[k] = (eMatch && ex_load) ||
                        (id_is_branch && mMatch && mem_load) ||
                        (mdu_busy && live && (src == pendDst));
   end

   // A second MDU op cannot start while one is in flight
   assign haz = id_valid && ((|opHaz) || (id_mdu && mdu_busy));

   assign mduIssue = id_valid && id_mdu && !stall_d && !exc_flush;

   // Stage control priority: reset, redirect, memory wait, hazard bubble, taken branch
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      flush_w = 1'b0;
      fwd_sel = '0;
      if (!rst) begin
         fwd_sel = fwdSel;
         if (exc_flush) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
         end else if (!mem_ready) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
         end else if (haz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end else if (branch_taken) begin
            flush_d = 1'b1;
         end
      end
   end

   // MDU scoreboard: latency countdown keeps running through memory waits; redirect aborts it
   always_ff @(posedge clk) begin
      if (rst) begin
         mduState <= IDLE;
         mduCnt   <= '0;
         pendDst  <= '0;
         mdu_busy <= 1'b0;
      end else if (exc_flush) begin
         mduState <= IDLE;
         mduCnt   <= '0;
         mdu_busy <= 1'b0;
      end else begin
         case (mduState)
            IDLE: begin
               if (mduIssue) begin
                  mduState <= BUSY;
                  mduCnt   <= id_mdu_lat;
                  pendDst  <= id_mdu_dst;
                  mdu_busy <= 1'b1;
               end
            end
            BUSY: begin
               mduCnt <= mduCnt - LAT_W'(1);
               // Result lands on this edge; write-through regfile lets the consumer issue next cycle
               if (mduCnt <= LAT_W'(1)) begin
                  mduState <= IDLE;
                  mdu_busy <= 1'b0;
               end
            end
            default: begin
               mduState <= IDLE;
               mdu_busy <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of decode-stall cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_d && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit
// Directed vectors with hand-computed expectations; the stimulus queues the expected
// outputs for each cycle and a negedge monitor pops and compares them.
module tb_hazard_scoreboard_unit;

   localparam int REG_AW = 7;
   localparam int NSRC   = 2;
   localparam int LAT_W  = 6;
   localparam int PERF_W = 16;

   // Stage-control patterns {stall_f,d,e,m,w, flush_d,e,m,w}
   localparam logic [8:0] NONE = 9'b00000_0000;
   localparam logic [8:0] HAZ  = 9'b11000_0100;
   localparam logic [8:0] FRZ  = 9'b11111_0000;
   localparam logic [8:0] EXC  = 9'b00000_1111;
   localparam logic [8:0] BRT  = 9'b00000_1000;

   localparam logic [6:0] HI = 7'd33;
   localparam logic [6:0] LO = 7'd34;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   id_valid;
   logic [NSRC*REG_AW-1:0] id_src;
   logic [NSRC-1:0]        id_src_used;
   logic                   id_is_branch;
   logic                   id_mdu;
   logic [LAT_W-1:0]       id_mdu_lat;
   logic [REG_AW-1:0]      id_mdu_dst;
   logic                   ex_regwrite;
   logic [REG_AW-1:0]      ex_wreg;
   logic                   ex_load;
   logic                   mem_regwrite;
   logic [REG_AW-1:0]      mem_wreg;
   logic                   mem_load;
   logic                   mem_ready;
   logic                   branch_taken;
   logic                   exc_flush;
   logic                   stall_f, stall_d, stall_e, stall_m, stall_w;
   logic                   flush_d, flush_e, flush_m, flush_w;
   logic [NSRC*2-1:0]      fwd_sel;
   logic                   mdu_busy;
   logic [PERF_W-1:0]      stall_cnt;

   hazard_scoreboard_unit #(
      .REG_AW(REG_AW), .NSRC(NSRC), .LAT_W(LAT_W), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
      .id_is_branch(id_is_branch), .id_mdu(id_mdu), .id_mdu_lat(id_mdu_lat),
      .id_mdu_dst(id_mdu_dst), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg), .ex_load(ex_load),
      .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg), .mem_load(mem_load),
      .mem_ready(mem_ready), .branch_taken(branch_taken), .exc_flush(exc_flush),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .flush_w(flush_w), .fwd_sel(fwd_sel), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string             tag;
      logic [12:0]       comb;
      logic              busy;
      logic [PERF_W-1:0] cnt;
   } expT;

   expT q[$];
   int  checks   = 0;
   int  failures = 0;
   int  expCnt   = 0;

   // Monitor: pop one expectation per cycle in which one was queued
   always @(negedge clk) begin
      if (q.size() > 0) begin
         expT it;
         logic [12:0] got;
         it  = q.pop_front();
         got = {stall_f, stall_d, stall_e, stall_m, stall_w,
                flush_d, flush_e, flush_m, flush_w, fwd_sel};
         checks++;
         if (got !== it.comb) begin
            failures++;
            $display("FAIL %s ctl/fwd: got %b required %b", it.tag, got, it.comb);
         end
         checks++;
         if (mdu_busy !== it.busy) begin
            failures++;
            $display("FAIL %s mdu_busy: got %b required %b", it.tag, mdu_busy, it.busy);
         end
         checks++;
         if (stall_cnt !== it.cnt) begin
            failures++;
            $display("FAIL %s stall_cnt: got %0d required %0d", it.tag, stall_cnt, it.cnt);
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clr();
      id_valid     = 1'b0;
      id_src       = '0;
      id_src_used  = '0;
      id_is_branch = 1'b0;
      id_mdu       = 1'b0;
      id_mdu_lat   = '0;
      id_mdu_dst   = '0;
      ex_regwrite  = 1'b0;
      ex_wreg      = '0;
      ex_load      = 1'b0;
      mem_regwrite = 1'b0;
      mem_wreg     = '0;
      mem_load     = 1'b0;
      mem_ready    = 1'b1;
      branch_taken = 1'b0;
      exc_flush    = 1'b0;
   endtask

   task automatic srcs(input logic [6:0] s0, input logic u0, input logic [6:0] s1, input logic u1);
      id_valid    = 1'b1;
      id_src      = {s1, s0};
      id_src_used = {u1, u0};
   endtask

   task automatic loadUse(input logic [6:0] r);
      srcs(r, 1'b1, 7'd0, 1'b0);
      ex_regwrite = 1'b1;
      ex_wreg     = r;
      ex_load     = 1'b1;
   endtask

   task automatic issue(input logic [5:0] lat, input logic [6:0] dst);
      id_valid   = 1'b1;
      id_mdu     = 1'b1;
      id_mdu_lat = lat;
      id_mdu_dst = dst;
   endtask

   // Queue this cycle's expectation, then advance to just after the next rising edge
   task automatic step(input string tag, input logic [8:0] ctl, input logic [3:0] fwd,
                       input logic busy);
      expT it;
      it.tag  = tag;
      it.comb = {ctl, fwd};
      it.busy = busy;
      it.cnt  = PERF_W'(expCnt);
      q.push_back(it);
      if (ctl[7] && expCnt < 65535) expCnt++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      rst = 1'b1;
      loadUse(7'd3);
      exc_flush = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step("reset", NONE, 4'b0000, 1'b0);
      rst = 1'b0;

      // Load-use then forward from M load data
      clr(); loadUse(7'd3);
      step("loaduse", HAZ, 4'b0000, 1'b0);
      clr(); srcs(7'd3, 1'b1, 7'd0, 1'b0); mem_regwrite = 1'b1; mem_wreg = 7'd3; mem_load = 1'b1;
      step("loaduse_fwd", NONE, 4'b0011, 1'b0);

      // E beats M; $zero and unused operands never forward
      clr(); srcs(7'd5, 1'b1, 7'd5, 1'b1); ex_regwrite = 1'b1; ex_wreg = 7'd5;
      mem_regwrite = 1'b1; mem_wreg = 7'd5; mem_load = 1'b1;
      step("e_over_m", NONE, 4'b0101, 1'b0);
      clr(); srcs(7'd0, 1'b1, 7'd7, 1'b1); ex_regwrite = 1'b1; ex_wreg = 7'd0;
      mem_regwrite = 1'b1; mem_wreg = 7'd7;
      step("zero_reg", NONE, 4'b1000, 1'b0);
      clr(); srcs(7'd9, 1'b1, 7'd9, 1'b0); mem_regwrite = 1'b1; mem_wreg = 7'd9; mem_load = 1'b1;
      step("unused_src", NONE, 4'b0011, 1'b0);
      clr(); loadUse(7'd3); id_valid = 1'b0;
      step("invalid_id", NONE, 4'b0000, 1'b0);

      // Branch on M load, taken branch, and priorities
      clr(); srcs(7'd4, 1'b1, 7'd0, 1'b0); id_is_branch = 1'b1;
      mem_regwrite = 1'b1; mem_wreg = 7'd4; mem_load = 1'b1;
      step("br_mload", HAZ, 4'b0011, 1'b0);
      clr(); srcs(7'd8, 1'b1, 7'd0, 1'b0); branch_taken = 1'b1;
      step("br_taken", BRT, 4'b0000, 1'b0);
      clr(); loadUse(7'd3); branch_taken = 1'b1;
      step("haz_over_br", HAZ, 4'b0000, 1'b0);
      clr(); loadUse(7'd3); branch_taken = 1'b1; mem_ready = 1'b0;
      step("memwait", FRZ, 4'b0000, 1'b0);
      clr(); loadUse(7'd3); branch_taken = 1'b1; mem_ready = 1'b0; exc_flush = 1'b1;
      step("exc_prio", EXC, 4'b0000, 1'b0);

      // MDU latency 4 then dependent mfhi
      clr(); issue(6'd4, HI);
      step("mdu_issue4", NONE, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         clr(); srcs(HI, 1'b1, 7'd0, 1'b0);
         step("mfhi_wait", HAZ, 4'b0000, 1'b1);
      end
      clr(); srcs(HI, 1'b1, 7'd0, 1'b0);
      step("mfhi_go", NONE, 4'b0000, 1'b0);

      // Structural stall, then latency-1 op
      clr(); issue(6'd2, 7'd10);
      step("mdu_issue2", NONE, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         clr(); issue(6'd1, 7'd11);
         step("mdu_struct", HAZ, 4'b0000, 1'b1);
      end
      clr(); issue(6'd1, 7'd11);
      step("mdu_issue1", NONE, 4'b0000, 1'b0);
      clr(); srcs(7'd5, 1'b1, 7'd0, 1'b0);
      step("mdu_lat1_busy", NONE, 4'b0000, 1'b1);
      clr(); srcs(7'd11, 1'b1, 7'd0, 1'b0);
      step("mdu_lat1_done", NONE, 4'b0000, 1'b0);

      // Redirect aborts an in-flight op
      clr(); issue(6'd8, HI);
      step("mdu_issue8", NONE, 4'b0000, 1'b0);
      clr(); srcs(HI, 1'b1, 7'd0, 1'b0); exc_flush = 1'b1;
      step("mdu_exc", EXC, 4'b0000, 1'b1);
      clr(); srcs(HI, 1'b1, 7'd0, 1'b0);
      step("mdu_after_exc", NONE, 4'b0000, 1'b0);

      // Redirect on the issue cycle suppresses the issue
      clr(); issue(6'd3, HI); exc_flush = 1'b1;
      step("issue_exc", EXC, 4'b0000, 1'b0);
      clr(); srcs(HI, 1'b1, 7'd0, 1'b0);
      step("issue_exc_nb", NONE, 4'b0000, 1'b0);

      // Counter keeps running through a memory wait
      clr(); issue(6'd2, LO);
      step("mdu_issue_lo", NONE, 4'b0000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         clr(); srcs(LO, 1'b1, 7'd0, 1'b0); mem_ready = 1'b0;
         step("mdu_memwait", FRZ, 4'b0000, 1'b1);
      end
      clr(); srcs(LO, 1'b1, 7'd0, 1'b0);
      step("mflo_go", NONE, 4'b0000, 1'b0);

      // Saturate the stall counter, then clear it with reset
      clr(); loadUse(7'd3);
      for (int i = 0; i < 65539; i++) begin
         @(posedge clk);
         #1;
      end
      expCnt = 65535;
      step("sat1", HAZ, 4'b0000, 1'b0);
      step("sat2", HAZ, 4'b0000, 1'b0);
      rst = 1'b1;
      step("rst_apply", NONE, 4'b0000, 1'b0);
      expCnt = 0;
      rst = 1'b0;
      clr();
      step("post_rst", NONE, 4'b0000, 1'b0);

      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
